// File: rtl/simd_calc_pkg.sv
// rtl/simd_calc_pkg.sv - function codes and FSM encodings shared by the SIMD calculus pipe
package simd_calc_pkg;

    localparam int FN_W = 4;

    localparam logic [FN_W-1:0] FN_RELU  = 4'h0;
    localparam logic [FN_W-1:0] FN_LEAKY = 4'h1;
    localparam logic [FN_W-1:0] FN_ABS   = 4'h2;
    localparam logic [FN_W-1:0] FN_SIGN  = 4'h3;
    localparam logic [FN_W-1:0] FN_CLAMP = 4'h4;
    localparam logic [FN_W-1:0] FN_MAX   = 4'h5;
    localparam logic [FN_W-1:0] FN_MIN   = 4'h6;
    // The only multi-cycle function; everything else loads the output register directly.
    localparam logic [FN_W-1:0] FN_SQRT  = 4'h8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ITER = 1'b1
    } state_t;

endpackage

// File: rtl/calc_isqrt_lane.sv
// rtl/calc_isqrt_lane.sv - one lane of the lockstep restoring square root, one root bit per step
module calc_isqrt_lane #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [2*W-1:0] radicand,
    output logic [W-1:0]   root
);

    logic [2*W-1:0] rad;
    logic [W-1:0]   rem;
    logic [W+1:0]   rem_sh;
    logic [W+1:0]   trial;
    logic           fits;

    // Before every step but the last, rem <= 2*root < 2^W, so W bits hold it exactly;
    // the final remainder is never read, so its truncation is harmless.
    assign rem_sh = {rem, rad[2*W-1 -: 2]};
    assign trial  = {root, 2'b01};
    assign fits   = rem_sh >= trial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
        end else if (load) begin
            rad  <= radicand;
            rem  <= '0;
            root <= '0;
        end else if (step) begin
            rad  <= {rad[2*W-3:0], 2'b00};
            rem  <= W'(fits ? rem_sh - trial : rem_sh);
            root <= {root[W-2:0], fits};
        end
    end

endmodule

// File: rtl/simd_calculus_pipe.sv
// rtl/simd_calculus_pipe.sv - handshaked multi-lane elementwise calculus unit with iterative sqrt
module simd_calculus_pipe
    import simd_calc_pkg::*;
#(
    parameter int FUNCTION_BITS = 4,
    parameter int BIT_WIDTH     = 32,
    parameter int NUM_LANES     = 4,
    parameter int LEAKY_SHIFT   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FUNCTION_BITS-1:0]       fn,
    input  logic [7:0]                     frac_bits,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in0,
    input  logic [NUM_LANES*BIT_WIDTH-1:0] data_in1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*BIT_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]           out_err
);

    localparam int CNT_W = $clog2(BIT_WIDTH);
    localparam logic signed [BIT_WIDTH-1:0] S_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] S_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    function automatic logic [BIT_WIDTH:0] lane_fn(
        input logic [FUNCTION_BITS-1:0]   code,
        input logic signed [BIT_WIDTH-1:0] a,
        input logic signed [BIT_WIDTH-1:0] b,
        input logic [7:0]                 f
    );
        logic signed [BIT_WIDTH-1:0] res;
        logic signed [BIT_WIDTH-1:0] lim;
        logic signed [BIT_WIDTH-1:0] one;
        logic                        err;
        res = '0;
        err = 1'b0;
        one = BIT_WIDTH'(1) << f;
        lim = (b == S_MIN) ? S_MAX : (b[BIT_WIDTH-1] ? -b : b);
        case (code)
            FUNCTION_BITS'(FN_RELU):  res = a[BIT_WIDTH-1] ? '0 : a;
            FUNCTION_BITS'(FN_LEAKY): res = a[BIT_WIDTH-1] ? (a >>> LEAKY_SHIFT) : a;
            FUNCTION_BITS'(FN_ABS): begin
                if (a == S_MIN) begin
                    res = S_MAX;
                    err = 1'b1;
                end else begin
                    res = a[BIT_WIDTH-1] ? -a : a;
                end
            end
            FUNCTION_BITS'(FN_SIGN): begin
                // With f = BIT_WIDTH-1 the value 1.0 does not fit, so +/-MAX stands in.
                if (a == '0) begin
                    res = '0;
                end else if (f == 8'(BIT_WIDTH-1)) begin
                    res = a[BIT_WIDTH-1] ? -S_MAX : S_MAX;
                    err = 1'b1;
                end else begin
                    res = a[BIT_WIDTH-1] ? -one : one;
                end
            end
            FUNCTION_BITS'(FN_CLAMP): begin
                if (a > lim)       res = lim;
                else if (a < -lim) res = -lim;
                else               res = a;
            end
            FUNCTION_BITS'(FN_MAX): res = (a > b) ? a : b;
            FUNCTION_BITS'(FN_MIN): res = (a < b) ? a : b;
            default: ;
        endcase
        return {err, res};
    endfunction

    state_t                         state, state_nx;
    logic [CNT_W-1:0]               cnt;
    logic                           done;
    logic [NUM_LANES-1:0]           neg_q;
    logic [NUM_LANES-1:0]           lane_neg;
    logic [NUM_LANES-1:0]           single_err;
    logic [NUM_LANES*BIT_WIDTH-1:0] single_res;
    logic [NUM_LANES*BIT_WIDTH-1:0] sqrt_res;
    logic [7:0]                     f_clamped;
    logic                           load_single, load_sqrt, start_sqrt, step;

    assign f_clamped = (frac_bits > 8'(BIT_WIDTH-1)) ? 8'(BIT_WIDTH-1) : frac_bits;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [BIT_WIDTH-1:0] a;
        logic signed [BIT_WIDTH-1:0] b;
        logic [BIT_WIDTH-1:0]        root;
        logic [2*BIT_WIDTH-1:0]      radicand;

        assign a        = data_in0[i*BIT_WIDTH +: BIT_WIDTH];
        assign b        = data_in1[i*BIT_WIDTH +: BIT_WIDTH];
        assign lane_neg[i] = a[BIT_WIDTH-1];
        assign {single_err[i], single_res[i*BIT_WIDTH +: BIT_WIDTH]} = lane_fn(fn, a, b, f_clamped);
        assign radicand = {{BIT_WIDTH{1'b0}}, a} << f_clamped;
        assign sqrt_res[i*BIT_WIDTH +: BIT_WIDTH] = neg_q[i] ? '0 : root;

        calc_isqrt_lane #(.W(BIT_WIDTH)) u_isqrt (
            .clk      (clk),
            .reset    (reset),
            .load     (start_sqrt),
            .step     (step),
            .radicand (radicand),
            .root     (root)
        );
    end

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        load_single = 1'b0;
        load_sqrt   = 1'b0;
        start_sqrt  = 1'b0;
        step        = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready) begin
                    if (fn == FUNCTION_BITS'(FN_SQRT)) begin
                        start_sqrt = 1'b1;
                        state_nx   = S_ITER;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            S_ITER: begin
                // done marks that all BIT_WIDTH steps have run; then wait for a free output slot.
                if (!done) begin
                    step = 1'b1;
                end else if (!out_valid || out_ready) begin
                    load_sqrt = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            neg_q     <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_err   <= '0;
        end else begin
            state <= state_nx;
            if (start_sqrt) begin
                cnt   <= CNT_W'(BIT_WIDTH-1);
                done  <= 1'b0;
                neg_q <= lane_neg;
            end else if (step) begin
                if (cnt == '0) done <= 1'b1;
                else           cnt  <= cnt - CNT_W'(1);
            end
            if (load_single) begin
                out_valid <= 1'b1;
                data_out  <= single_res;
                out_err   <= single_err;
            end else if (load_sqrt) begin
                out_valid <= 1'b1;
                data_out  <= sqrt_res;
                out_err   <= neg_q;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simd_calculus_pipe.sv
// tb/tb_simd_calculus_pipe.sv - scoreboard bench for simd_calculus_pipe
module tb_simd_calculus_pipe;

    localparam int W = 32;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     fn = '0;
    logic [7:0]     frac_bits = '0;
    logic [L*W-1:0] data_in0 = '0;
    logic [L*W-1:0] data_in1 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [L*W-1:0] data_out;
    logic [L-1:0]   out_err;

    int total = 0;
    int bad = 0;
    logic [L+L*W-1:0] exp_q[$];
    logic [L+L*W-1:0] exp_v;

    simd_calculus_pipe #(
        .FUNCTION_BITS (4),
        .BIT_WIDTH     (W),
        .NUM_LANES     (L),
        .LEAKY_SHIFT   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fn        (fn),
        .frac_bits (frac_bits),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got err=%b data=%h, required no output", out_err, data_out);
            end else begin
                exp_v = exp_q.pop_front();
                if ({out_err, data_out} !== exp_v) begin
                    bad++;
                    $display("FAIL sb_result: got err=%b data=%h, required err=%b data=%h",
                             out_err, data_out, exp_v[L*W +: L], exp_v[L*W-1:0]);
                end
            end
        end
    end

    function automatic logic [L*W-1:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] m_sqrt(input logic [31:0] a, input int f);
        longint unsigned r, lo, hi, mid;
        r  = longint'(a) << f;
        lo = 0;
        hi = 64'h8000_0000;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= r) lo = mid;
            else                hi = mid - 1;
        end
        return lo[31:0];
    endfunction

    function automatic logic [31:0] m_lane(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'h0:    return ($signed(a) < 0) ? 32'd0 : a;
            4'h5:    return ($signed(a) >= $signed(b)) ? a : b;
            4'h6:    return ($signed(a) <= $signed(b)) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic send(input logic [3:0] f, input logic [7:0] fb, input logic [L*W-1:0] a,
                        input logic [L*W-1:0] b, input logic [L+L*W-1:0] e, input bit push,
                        output int cycles);
        bit acc;
        fn = f;
        frac_bits = fb;
        data_in0 = a;
        data_in1 = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        acc = 1'b0;
        cycles = 0;
        while (!acc && cycles < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles, required acceptance", cycles);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || data_out !== '0 || out_err !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h err=%b, required 0/0/0", out_valid, data_out, out_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_relu();
        int n;
        out_ready = 1'b1;
        send(4'h0, 8'd16, pk(5, -3, 0, 32'h7FFFFFFF), '0, {4'b0000, pk(5, 0, 0, 32'h7FFFFFFF)}, 1, n);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL relu_latency: got out_valid=%b after accept edge, required 1", out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL relu_consumed: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_abs_sign();
        int n;
        out_ready = 1'b1;
        send(4'h2, 8'd16, pk(32'h80000000, -7, 0, 100), '0,
             {4'b0001, pk(32'h7FFFFFFF, 7, 0, 100)}, 1, n);
        send(4'h3, 8'd16, pk(-7, 0, 9, 32'h12345), '0,
             {4'b0000, pk(32'hFFFF0000, 0, 32'h00010000, 32'h00010000)}, 1, n);
        send(4'h3, 8'd200, pk(5, -5, 0, 1), '0,
             {4'b1011, pk(32'h7FFFFFFF, 32'h80000001, 0, 32'h7FFFFFFF)}, 1, n);
        drain();
    endtask

    task automatic test_misc_ops();
        int n;
        logic [31:0] a[L];
        logic [31:0] b[L];
        logic [3:0]  f;
        out_ready = 1'b1;
        send(4'h1, 8'd0, pk(-16, 16, -1, 32'h80000000), '0,
             {4'b0000, pk(-2, 16, -1, 32'hF0000000)}, 1, n);
        send(4'hF, 8'd0, pk(20, -20, 3, 5), pk(-10, -10, -10, -10), {4'b0000, pk(0, 0, 0, 0)}, 1, n);
        send(4'h4, 8'd0, pk(20, -20, 3, 32'h80000000), pk(-10, -10, -10, 32'h80000000),
             {4'b0000, pk(10, -10, 3, 32'h80000001)}, 1, n);
        for (int t = 0; t < 4; t++) begin
            f = (t % 2 == 0) ? 4'h5 : 4'h6;
            for (int i = 0; i < L; i++) begin
                a[i] = $urandom;
                b[i] = $urandom;
            end
            send(f, 8'd0, pk(a[0], a[1], a[2], a[3]), pk(b[0], b[1], b[2], b[3]),
                 {4'b0000, pk(m_lane(f, a[0], b[0]), m_lane(f, a[1], b[1]),
                              m_lane(f, a[2], b[2]), m_lane(f, a[3], b[3]))}, 1, n);
        end
        drain();
    endtask

    task automatic test_sqrt();
        int n, k;
        bit rdy_seen;
        logic [31:0] a[L];
        out_ready = 1'b1;
        send(4'h8, 8'd16, pk(32'h00040000, 32'h00020000, -1, 32'h7FFFFFFF), '0,
             {4'b0100, pk(32'h00020000, 32'h00016A09, 0, m_sqrt(32'h7FFFFFFF, 16))}, 1, n);
        k = 0;
        rdy_seen = 1'b0;
        while (!out_valid && k < 60) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (k != 33) begin
            bad++;
            $display("FAIL sqrt_latency: got %0d cycles, required 33", k);
        end
        total++;
        if (rdy_seen) begin
            bad++;
            $display("FAIL sqrt_in_ready: got in_ready=1 during iteration, required 0");
        end
        drain();
        for (int i = 0; i < L; i++) a[i] = $urandom & 32'h7FFFFFFF;
        send(4'h8, 8'd0, pk(a[0], a[1], a[2], a[3]), '0,
             {4'b0000, pk(m_sqrt(a[0], 0), m_sqrt(a[1], 0), m_sqrt(a[2], 0), m_sqrt(a[3], 0))}, 1, n);
        drain();
        send(4'h8, 8'd40, pk(1, 0, 32'h7FFFFFFF, 4), '0,
             {4'b0000, pk(m_sqrt(1, 31), 0, m_sqrt(32'h7FFFFFFF, 31), m_sqrt(4, 31))}, 1, n);
        drain();
    endtask

    task automatic test_backpressure();
        int n, k;
        logic [L*W-1:0] exp_a, exp_b, exp_s;
        exp_a = pk(1, 0, 3, 4);
        exp_b = pk(7, 2, 9, 5);
        exp_s = pk(m_sqrt(9, 0), m_sqrt(16, 0), m_sqrt(100, 0), m_sqrt(2, 0));
        out_ready = 1'b0;
        send(4'h0, 8'd0, pk(1, -2, 3, 4), '0, {4'b0000, exp_a}, 1, n);
        fn = 4'h5;
        data_in0 = pk(7, 1, 9, -5);
        data_in1 = pk(6, 2, 8, 5);
        in_valid = 1'b1;
        exp_q.push_back({4'b0000, exp_b});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || data_out !== exp_a || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable: got ready=%b valid=%b data=%h, required 0/1/%h", in_ready, out_valid, data_out, exp_a);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || data_out !== exp_b) begin
            bad++;
            $display("FAIL swap_load: got valid=%b data=%h, required 1/%h", out_valid, data_out, exp_b);
        end
        drain();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        send(4'h8, 8'd0, pk(9, 16, 100, 2), '0, {4'b0000, exp_s}, 1, n);
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || data_out !== exp_s || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL sqrt_hold: got valid=%b ready=%b data=%h, required 1/0/%h", out_valid, in_ready, data_out, exp_s);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] a[L];
        logic [31:0] b[L];
        logic [3:0]  f;
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            f = (t % 3 == 0) ? 4'h0 : ((t % 3 == 1) ? 4'h5 : 4'h6);
            for (int i = 0; i < L; i++) begin
                a[i] = $urandom;
                b[i] = $urandom;
            end
            send(f, 8'd0, pk(a[0], a[1], a[2], a[3]), pk(b[0], b[1], b[2], b[3]),
                 {4'b0000, pk(m_lane(f, a[0], b[0]), m_lane(f, a[1], b[1]),
                              m_lane(f, a[2], b[2]), m_lane(f, a[3], b[3]))}, 1, n);
            total++;
            if (n != 1 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_rate: got cycles=%0d valid=%b, required 1/1", n, out_valid);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_sqrt();
        int n;
        out_ready = 1'b1;
        send(4'h8, 8'd16, pk(32'h00040000, 5, 6, 7), '0, '0, 0, n);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || data_out !== '0 || out_err !== '0) begin
            bad++;
            $display("FAIL reset_abort: got valid=%b data=%h err=%b, required 0/0/0", out_valid, data_out, out_err);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(4'h0, 8'd0, pk(-1, 2, -3, 4), '0, {4'b0000, pk(0, 2, 0, 4)}, 1, n);
        total++;
        if (n != 1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_relu: got cycles=%0d valid=%b, required 1/1", n, out_valid);
        end
        drain();
        repeat (40) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_relu();
        test_abs_sign();
        test_misc_ops();
        test_sqrt();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sqrt();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
